// File: rtl/q_update_unit_pkg.sv
// Shared types and constants for the Q-table update path.
// Optional statistics counters are enabled by defining Q_UPD_STATS_EN.
package q_learn_pkg;

  localparam int Q_W     = 16;
  localparam int FRAC_W  = 8;
  localparam int NUM_ACT = 9;
  localparam int ACT_W   = 4;
  localparam int GAMMA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CALC,
    ST_WRITE,
    ST_ERR
  } upd_state_e;

  // Clamp a signed 19-bit intermediate onto the unsigned Q8.8 range.
  function automatic logic [Q_W-1:0] sat_u16(input logic signed [18:0] v);
    if (v < 19'sd0)
      return '0;
    else if (v > 19'sd65535)
      return '1;
    else
      return v[Q_W-1:0];
  endfunction

endpackage

// File: rtl/q_update_unit_if.sv
// Update-request handshake bundle between a requester and q_update_unit.
interface q_upd_if #(parameter int STATE_W = 6);
  import q_learn_pkg::*;

  logic                upd_valid;
  logic                upd_ready;
  logic [STATE_W-1:0]  upd_state;
  logic [ACT_W-1:0]    upd_action;
  logic [Q_W-1:0]      upd_reward;
  logic [Q_W-1:0]      upd_qmax;
  logic [GAMMA_W-1:0]  upd_gamma;
  logic                upd_done;
  logic                upd_err;

  modport master (
    output upd_valid, upd_state, upd_action, upd_reward, upd_qmax, upd_gamma,
    input  upd_ready, upd_done, upd_err
  );

  modport slave (
    input  upd_valid, upd_state, upd_action, upd_reward, upd_qmax, upd_gamma,
    output upd_ready, upd_done, upd_err
  );

endinterface

// File: rtl/q_update_unit_td_calc.sv
// Combinational temporal-difference datapath:
// Q_new = sat(Q_old + ((r + gamma*maxQ' - Q_old) >>> ALPHA_SHIFT)).
module q_td_calc
  import q_learn_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  logic [Q_W-1:0]     q_old,
  input  logic [Q_W-1:0]     reward,
  input  logic [Q_W-1:0]     qmax,
  input  logic [GAMMA_W-1:0] gamma,
  output logic [Q_W-1:0]     q_new,
  output logic               sat
);

  logic [Q_W+GAMMA_W-1:0] prod;
  logic [Q_W-1:0]         gq;
  logic signed [18:0]     target;
  logic signed [18:0]     delta;
  logic signed [18:0]     step;
  logic signed [18:0]     sum;

  // Discounted next-state value, TD error, scaled step and clipped result.
  always_comb begin
    prod   = (Q_W+GAMMA_W)'(qmax) * (Q_W+GAMMA_W)'(gamma);
    gq     = Q_W'(prod >> FRAC_W);
    target = signed'({{3{reward[Q_W-1]}}, reward}) + signed'({3'b000, gq});
    delta  = target - signed'({3'b000, q_old});
    step   = delta >>> ALPHA_SHIFT;
    sum    = signed'({3'b000, q_old}) + step;
    q_new  = sat_u16(sum);
    sat    = sum[18] | (|sum[17:16]);
  end

endmodule

// File: rtl/q_update_unit.sv
// Q-table writer: one read-modify-write TD update per accepted request.
// Define Q_UPD_STATS_EN to add stat_updates / stat_sats counters.
module q_update_unit
  import q_learn_pkg::*;
#(
  parameter int STATE_W     = 6,
  parameter int ALPHA_SHIFT = 2,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  q_upd_if.slave            upd,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [Q_W-1:0]    mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [Q_W-1:0]    mem_wr_data
`ifdef Q_UPD_STATS_EN
  ,
  output logic [15:0]       stat_updates,
  output logic [15:0]       stat_sats
`endif
);

  upd_state_e         state, state_nxt;
  logic [STATE_W-1:0] s_q;
  logic [ACT_W-1:0]   a_q;
  logic [Q_W-1:0]     r_q;
  logic [Q_W-1:0]     qmax_q;
  logic [GAMMA_W-1:0] gamma_q;
  logic [Q_W-1:0]     qold_q;
  logic [Q_W-1:0]     qnew_q;
  logic [Q_W-1:0]     calc_q;
  logic [ADDR_W-1:0]  addr;
  logic               accept;

  assign accept = upd.upd_valid && (state == ST_IDLE);
  assign addr   = ADDR_W'(s_q) * ADDR_W'(NUM_ACT) + ADDR_W'(a_q);

  assign mem_rd_addr = addr;
  assign mem_wr_addr = addr;
  assign mem_wr_data = qnew_q;

`ifdef Q_UPD_STATS_EN
  logic calc_sat;
  logic sat_q;
`endif

  q_td_calc #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_calc (
    .q_old  (qold_q),
    .reward (r_q),
    .qmax   (qmax_q),
    .gamma  (gamma_q),
    .q_new  (calc_q),
`ifdef Q_UPD_STATS_EN
    .sat    (calc_sat)
`else
    .sat    ()
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request capture, old-Q capture and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      a_q     <= '0;
      r_q     <= '0;
      qmax_q  <= '0;
      gamma_q <= '0;
      qold_q  <= '0;
      qnew_q  <= '0;
    end else begin
      if (accept) begin
        s_q     <= upd.upd_state;
        a_q     <= upd.upd_action;
        r_q     <= upd.upd_reward;
        qmax_q  <= upd.upd_qmax;
        gamma_q <= upd.upd_gamma;
      end
      if (state == ST_WAIT) qold_q <= mem_rd_data;
      if (state == ST_CALC) qnew_q <= calc_q;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt    = state;
    upd.upd_ready = 1'b0;
    upd.upd_done  = 1'b0;
    upd.upd_err   = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        upd.upd_ready = 1'b1;
        if (upd.upd_valid)
          state_nxt = (upd.upd_action > ACT_W'(NUM_ACT - 1)) ? ST_ERR : ST_READ;
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:  state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem_wr_en    = 1'b1;
        upd.upd_done = 1'b1;
        state_nxt    = ST_IDLE;
      end
      ST_ERR: begin
        upd.upd_err = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef Q_UPD_STATS_EN
  // Update and saturation counters; counted at write time so aborted updates do not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q        <= 1'b0;
      stat_updates <= '0;
      stat_sats    <= '0;
    end else begin
      if (state == ST_CALC) sat_q <= calc_sat;
      if (state == ST_WRITE) begin
        stat_updates <= stat_updates + 16'd1;
        if (sat_q) stat_sats <= stat_sats + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_q_update_unit.sv
// Directed bench for q_update_unit with a synchronous Q-table memory model.
// Define Q_UPD_STATS_EN to also check the statistics counters.
module tb_q_update_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
`ifdef Q_UPD_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_sats;
`endif

  q_upd_if #(.STATE_W(6)) upd ();

  q_update_unit #(.STATE_W(6), .ALPHA_SHIFT(2), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd         (upd),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
`ifdef Q_UPD_STATS_EN
    ,
    .stat_updates (stat_updates),
    .stat_sats    (stat_sats)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Q-table model: read data one cycle after the strobe; preload port for the bench.
  logic [15:0] mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  // Strobe / accept monitor sampled on the falling edge.
  int         cyc = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         acc_n = 0;
  int         acc_prev = 0;
  int         acc_last = 0;
  logic [9:0] last_raddr = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (upd.upd_valid && upd.upd_ready) begin
      acc_n    <= acc_n + 1;
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
    if (mem_rd_en) begin
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= mem_rd_addr;
    end
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  // Issue one request; returns cycles from drive to done/err (0 if none within budget).
  // Leaves time at #1 after the edge that raised done/err.
  task automatic request(input logic [5:0] s, input logic [3:0] a, input logic [15:0] r,
                         input logic [15:0] q, input logic [7:0] g, output int lat);
    int n;
    lat = 0;
    n   = 0;
    while (!upd.upd_ready && n < 20) begin
      tick();
      n++;
    end
    upd.upd_state  = s;
    upd.upd_action = a;
    upd.upd_reward = r;
    upd.upd_qmax   = q;
    upd.upd_gamma  = g;
    upd.upd_valid  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        upd.upd_valid  = 1'b0;
        upd.upd_state  = ~s;
        upd.upd_action = 4'd3;
        upd.upd_reward = ~r;
        upd.upd_qmax   = ~q;
        upd.upd_gamma  = ~g;
      end
      if (upd.upd_done || upd.upd_err) begin
        lat = i;
        break;
      end
    end
  endtask

  int          lat;
  int          rd0;
  int          wr0;
  int          acc0;
  int          dn;
  logic [15:0] w1;
  logic [15:0] w2;

  initial begin
    rst_n          = 1'b0;
    pre_en         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;
    upd.upd_valid  = 1'b0;
    upd.upd_state  = '0;
    upd.upd_action = '0;
    upd.upd_reward = '0;
    upd.upd_qmax   = '0;
    upd.upd_gamma  = '0;
    repeat (3) tick();

    // Reset values
    check("rst_ready",   upd.upd_ready, 1);
    check("rst_rd_en",   mem_rd_en, 0);
    check("rst_wr_en",   mem_wr_en, 0);
    check("rst_done",    upd.upd_done, 0);
    check("rst_err",     upd.upd_err, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    rst_n = 1'b1;
    tick();

    preload(10'd11, 16'h0100);  // s=1 a=2
    preload(10'd20, 16'hFF00);  // s=2 a=2
    preload(10'd30, 16'h0004);  // s=3 a=3
    preload(10'd53, 16'h1234);  // s=5 a=8
    preload(10'd18, 16'h0100);  // s=2 a=0
    preload(10'd37, 16'h0100);  // s=4 a=1

    // Nominal update
    request(6'd1, 4'd2, 16'h0080, 16'h0200, 8'hE6, lat);
    check("t1_latency", lat, 4);
    check("t1_wr_en",   mem_wr_en, 1);
    check("t1_wr_data", mem_wr_data, 16'h0153);
    check("t1_wr_addr", mem_wr_addr, 11);
    check("t1_rd_addr", last_raddr, 11);

    // High saturation
    request(6'd2, 4'd2, 16'h7FFF, 16'hFFFF, 8'hFF, lat);
    check("t2_wr_data", mem_wr_data, 16'hFFFF);

    // Low saturation
    request(6'd3, 4'd3, 16'h8000, 16'h0000, 8'h00, lat);
    check("t3_wr_data", mem_wr_data, 16'h0000);

    // Highest legal action: 0x1234 + ((0 - 0x1234) >>> 2) = 0x0DA7
    request(6'd5, 4'd8, 16'h0000, 16'h0000, 8'h00, lat);
    check("t4_wr_addr", mem_wr_addr, 53);
    check("t4_rd_addr", last_raddr, 53);
    check("t4_wr_data", mem_wr_data, 16'h0DA7);

    // Illegal action
    tick();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    request(6'd5, 4'd9, 16'h0000, 16'h0000, 8'h00, lat);
    check("t4_err_lat",   lat, 1);
    check("t4_err",       upd.upd_err, 1);
    check("t4_err_done",  upd.upd_done, 0);
    check("t4_err_ready", upd.upd_ready, 0);
    tick();
    check("t4_ready_after", upd.upd_ready, 1);
    check("t4_err_pulse",   upd.upd_err, 0);
    tick();
    check("t4_no_rd", rd_cnt, rd0);
    check("t4_no_wr", wr_cnt, wr0);

    // Back-to-back on one address with valid held
    acc0           = acc_n;
    dn             = 0;
    w1             = '0;
    w2             = '0;
    upd.upd_state  = 6'd2;
    upd.upd_action = 4'd0;
    upd.upd_reward = 16'h0080;
    upd.upd_qmax   = 16'h0200;
    upd.upd_gamma  = 8'hE6;
    upd.upd_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (upd.upd_done) begin
        dn++;
        if (dn == 1) w1 = mem_wr_data;
        else         w2 = mem_wr_data;
      end else if (dn == 1 && !upd.upd_ready) begin
        upd.upd_valid = 1'b0;
      end
      if (dn == 2) break;
    end
    upd.upd_valid = 1'b0;
    check("t5_done_count", dn, 2);
    check("t5_first",      w1, 16'h0153);
    check("t5_second",     w2, 16'h0191);
    repeat (3) tick();
    check("t5_accepts",    acc_n - acc0, 2);
    check("t5_spacing",    acc_last - acc_prev, 5);
`ifdef Q_UPD_STATS_EN
    check("stat_updates", stat_updates, 6);
    check("stat_sats",    stat_sats, 2);
`endif

    // Reset while in CALC
    upd.upd_state  = 6'd4;
    upd.upd_action = 4'd1;
    upd.upd_reward = 16'h0080;
    upd.upd_qmax   = 16'h0200;
    upd.upd_gamma  = 8'hE6;
    upd.upd_valid  = 1'b1;
    tick();
    upd.upd_valid  = 1'b0;
    tick();
    tick();
    check("t6_calc_ready", upd.upd_ready, 0);
    check("t6_calc_wr",    mem_wr_en, 0);
    wr0   = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready",   upd.upd_ready, 1);
    check("t6_rst_wr_en",   mem_wr_en, 0);
    check("t6_rst_done",    upd.upd_done, 0);
    check("t6_rst_rd_addr", mem_rd_addr, 0);
    check("t6_rst_wr_data", mem_wr_data, 0);
    tick();
    tick();
    check("t6_no_write", wr_cnt, wr0);
    rst_n = 1'b1;
    tick();
    request(6'd4, 4'd1, 16'h0080, 16'h0200, 8'hE6, lat);
    check("t6_latency", lat, 4);
    check("t6_wr_data", mem_wr_data, 16'h0153);
    check("t6_wr_addr", mem_wr_addr, 37);
`ifdef Q_UPD_STATS_EN
    tick();
    check("stat_updates_after_rst", stat_updates, 1);
    check("stat_sats_after_rst",    stat_sats, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
